// File: rtl/din_feeder.sv
// Instruction feeder: buffers switch-loaded words in a FIFO and issues them to the processor with a Run strobe.
// Optional WAIT-state watchdog is enabled by defining DIN_FEEDER_WATCHDOG_EN.
module din_feeder #(
    parameter int DEPTH = 8
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Load,
    input  logic [7:0] Data,
    input  logic       Start,
    input  logic       Done,
    output logic [7:0] DIN,
    output logic       Run,
    output logic [4:0] Count,
    output logic       Full,
    output logic       Empty,
    output logic       Busy,
    output logic       Error
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULLCNT = 5'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, IMM, WAIT} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [7:0]    head;
    logic          head_imm;
    logic          issuable;
    logic          pop;
    logic          push;

    // A move-immediate opcode needs its immediate already buffered before it may issue.
    assign head     = mem[rd_ptr];
    assign head_imm = (head[7:6] == 2'b01);
    assign issuable = head_imm ? (Count >= 5'd2) : (Count >= 5'd1);
    assign pop      = (state == ISSUE) || (state == IMM);
    assign push     = Load && (!Full || pop);
    assign Full     = (Count == FULLCNT);
    assign Empty    = (Count == 5'd0);
    assign DIN      = Empty ? 8'h00 : head;

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= Data;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            Count  <= 5'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                Count <= Count + 5'd1;
            end else if (pop && !push) begin
                Count <= Count - 5'd1;
            end
        end
    end

`ifdef DIN_FEEDER_WATCHDOG_EN
    logic [7:0] wd_cnt;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= IDLE;
            Run    <= 1'b0;
            Busy   <= 1'b0;
            Error  <= 1'b0;
            wd_cnt <= 8'd0;
        end else begin
            Run <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start && issuable) begin
                        state <= ISSUE;
                        Run   <= 1'b1;
                        Busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    state  <= head_imm ? IMM : WAIT;
                    wd_cnt <= 8'd0;
                end
                IMM: begin
                    state  <= WAIT;
                    wd_cnt <= 8'd0;
                end
                WAIT: begin
                    if (Done) begin
                        if (Start && issuable) begin
                            state <= ISSUE;
                            Run   <= 1'b1;
                        end else begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end
                    end else if (wd_cnt == 8'hFF) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        Error <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end
`else
    assign Error = 1'b0;

    // Without the watchdog, WAIT only ever exits on Done.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            Run   <= 1'b0;
            Busy  <= 1'b0;
        end else begin
            Run <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start && issuable) begin
                        state <= ISSUE;
                        Run   <= 1'b1;
                        Busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= head_imm ? IMM : WAIT;
                end
                IMM: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (Done) begin
                        if (Start && issuable) begin
                            state <= ISSUE;
                            Run   <= 1'b1;
                        end else begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_din_feeder.sv
// Scoreboard bench for din_feeder: accepted loads are queued as expected issue order, a monitor checks every issued word.
// Define DIN_FEEDER_WATCHDOG_EN for both files to exercise the watchdog scenario.
module tb_din_feeder;

    localparam int DEPTH = 8;

    logic       Clock;
    logic       Resetn;
    logic       Load;
    logic [7:0] Data;
    logic       Start;
    logic       Done;
    logic [7:0] DIN;
    logic       Run;
    logic [4:0] Count;
    logic       Full;
    logic       Empty;
    logic       Busy;
    logic       Error;

    logic       done_dir;
    logic       done_auto;
    logic       auto_en;
    logic       imm_pending;
    logic [7:0] exp_q[$];
    int         total;
    int         bad;

    assign Done = done_dir | done_auto;

    din_feeder #(.DEPTH(DEPTH)) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .Load  (Load),
        .Data  (Data),
        .Start (Start),
        .Done  (Done),
        .DIN   (DIN),
        .Run   (Run),
        .Count (Count),
        .Full  (Full),
        .Empty (Empty),
        .Busy  (Busy),
        .Error (Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", name, actual, expected);
        end
    endtask

    // One load strobe; the model accepts it if the buffer has room at the edge (pops at that edge already retired).
    task automatic applyStimulus(input logic [7:0] d);
        Load = 1'b1;
        Data = d;
        @(posedge Clock);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(d);
        end
        #1;
        Load = 1'b0;
    endtask

    task automatic pulseDone();
        done_dir = 1'b1;
        @(posedge Clock);
        #1;
        done_dir = 1'b0;
    endtask

    task automatic waitRun(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge Clock);
            if (Run) seen = 1'b1;
        end
        checkOutput(name, int'(seen), 1);
    endtask

    // Monitor: every Run cycle must present the oldest accepted word; a move-immediate is followed by its immediate.
    always @(negedge Clock) begin
        logic [7:0] w;
        if (!Resetn) begin
            exp_q.delete();
            imm_pending = 1'b0;
        end else if (imm_pending) begin
            imm_pending = 1'b0;
            checkOutput("imm cycle run", int'(Run), 0);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                checkOutput("immediate word", int'(DIN), int'(w));
            end
        end else if (Run) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected issue: got DIN 'h%0h expected no Run", DIN);
            end else begin
                w = exp_q.pop_front();
                checkOutput("issue word", int'(DIN), int'(w));
                imm_pending = (w[7:6] == 2'b01);
            end
        end
    end

    // Automatic Done responder for the random phase, always answering while in WAIT.
    initial begin
        done_auto = 1'b0;
        forever begin
            @(negedge Clock);
            while (auto_en && Run) begin
                repeat ($urandom_range(2, 5)) @(negedge Clock);
                done_auto = 1'b1;
                @(negedge Clock);
                done_auto = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        total       = 0;
        bad         = 0;
        imm_pending = 1'b0;
        auto_en     = 1'b0;
        done_dir    = 1'b0;
        Resetn      = 1'b0;
        Load        = 1'b0;
        Data        = 8'h00;
        Start       = 1'b0;

        #3;
        checkOutput("reset run", int'(Run), 0);
        checkOutput("reset busy", int'(Busy), 0);
        checkOutput("reset empty", int'(Empty), 1);
        checkOutput("reset full", int'(Full), 0);
        checkOutput("reset din", int'(DIN), 0);
        checkOutput("reset count", int'(Count), 0);
        checkOutput("reset error", int'(Error), 0);

        @(negedge Clock);
        Resetn = 1'b1;

        // Loads with Start low only buffer.
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        @(negedge Clock);
        checkOutput("s1 count", int'(Count), 2);
        checkOutput("s1 din", int'(DIN), 'h12);
        checkOutput("s1 run", int'(Run), 0);
        checkOutput("s1 busy", int'(Busy), 0);

        // Issue, hold in WAIT, then Done chains straight into the next issue.
        Start = 1'b1;
        waitRun("s2 first run");
        checkOutput("s2 din first", int'(DIN), 'h12);
        repeat (3) @(negedge Clock);
        checkOutput("s2 wait busy", int'(Busy), 1);
        checkOutput("s2 wait run", int'(Run), 0);
        pulseDone();
        @(negedge Clock);
        checkOutput("s2 run after done", int'(Run), 1);
        checkOutput("s2 din second", int'(DIN), 'h34);
        Start = 1'b0;
        @(negedge Clock);
        pulseDone();
        @(negedge Clock);
        checkOutput("s2 idle busy", int'(Busy), 0);
        checkOutput("s2 idle empty", int'(Empty), 1);

        // Done during the Run cycle itself is ignored.
        applyStimulus(8'h01);
        Start = 1'b1;
        waitRun("done-in-run issue");
        Start    = 1'b0;
        done_dir = 1'b1;
        @(posedge Clock);
        #1;
        done_dir = 1'b0;
        @(negedge Clock);
        checkOutput("done in run ignored", int'(Busy), 1);
        pulseDone();
        @(negedge Clock);
        checkOutput("done in run idle", int'(Busy), 0);

        // Lone move-immediate waits for its immediate.
        Start = 1'b1;
        applyStimulus(8'h40);
        repeat (3) @(negedge Clock);
        checkOutput("s3 lone imm busy", int'(Busy), 0);
        checkOutput("s3 lone imm count", int'(Count), 1);
        checkOutput("s3 lone imm run", int'(Run), 0);
        applyStimulus(8'hA5);
        waitRun("s3 imm issue");
        checkOutput("s3 issue din", int'(DIN), 'h40);
        @(negedge Clock);
        checkOutput("s3 imm run", int'(Run), 0);
        checkOutput("s3 imm din", int'(DIN), 'hA5);
        checkOutput("s3 imm busy", int'(Busy), 1);
        Start = 1'b0;
        @(negedge Clock);
        checkOutput("s3 count after imm", int'(Count), 0);
        pulseDone();
        @(negedge Clock);
        checkOutput("s3 idle", int'(Busy), 0);

        // Overfill, then push and pop in the same cycle while full.
        for (int i = 0; i <= DEPTH; i++) begin
            applyStimulus(8'(8'h80 + i));
        end
        @(negedge Clock);
        checkOutput("s4 full", int'(Full), 1);
        checkOutput("s4 count", int'(Count), DEPTH);
        checkOutput("s4 head", int'(DIN), 'h80);
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        applyStimulus(8'hC7);
        @(negedge Clock);
        checkOutput("s4 push pop count", int'(Count), DEPTH);
        checkOutput("s4 push pop full", int'(Full), 1);

        // Asynchronous reset while in WAIT.
        @(posedge Clock);
        #2;
        Resetn = 1'b0;
        #1;
        checkOutput("s5 run", int'(Run), 0);
        checkOutput("s5 count", int'(Count), 0);
        checkOutput("s5 empty", int'(Empty), 1);
        checkOutput("s5 busy", int'(Busy), 0);
        checkOutput("s5 din", int'(DIN), 0);
        @(negedge Clock);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;

`ifdef DIN_FEEDER_WATCHDOG_EN
        applyStimulus(8'h0F);
        Start = 1'b1;
        waitRun("wd issue");
        Start = 1'b0;
        for (int i = 0; i < 400 && Busy; i++) @(negedge Clock);
        checkOutput("wd back to idle", int'(Busy), 0);
        checkOutput("wd error", int'(Error), 1);
        applyStimulus(8'h22);
        Start = 1'b1;
        waitRun("wd issue after error");
        Start = 1'b0;
        @(negedge Clock);
        pulseDone();
        @(negedge Clock);
        checkOutput("wd error sticky", int'(Error), 1);
        checkOutput("wd idle again", int'(Busy), 0);
`else
        applyStimulus(8'h0F);
        Start = 1'b1;
        waitRun("nowd issue");
        Start = 1'b0;
        repeat (300) @(negedge Clock);
        checkOutput("nowd still waiting", int'(Busy), 1);
        checkOutput("nowd error", int'(Error), 0);
        pulseDone();
        @(negedge Clock);
        checkOutput("nowd idle", int'(Busy), 0);
`endif

        // Random traffic with Start held high and an automatic Done responder.
        auto_en = 1'b1;
        Start   = 1'b1;
        @(posedge Clock);
        #1;
        for (int i = 0; i < 120; i++) begin
            if (exp_q.size() <= DEPTH - 2 && $urandom_range(0, 1) == 1) begin
                applyStimulus(8'($urandom_range(0, 255)));
            end else begin
                @(posedge Clock);
                #1;
            end
            checkOutput("random count track", int'(Count), exp_q.size());
        end
        applyStimulus(8'h00);
        for (int i = 0; i < 3000 && !(exp_q.size() == 0 && !imm_pending && !Busy); i++) begin
            @(negedge Clock);
        end
        checkOutput("random drained", int'(exp_q.size() == 0 && !Busy), 1);
        checkOutput("random final count", int'(Count), 0);
        checkOutput("random final empty", int'(Empty), 1);
        auto_en = 1'b0;
        Start   = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
